// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline constants, tag type and forward-select helper
package riscv_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } e_tag_t;

    // The M producer is younger than the W producer, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              wr_w
    );
        if (wr_m && rd_m == rs)
            return FWD_MEM;
        else if (wr_w && rd_w == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// rtl/hazard_tag_pipe.sv - E/M/W register tag pipeline with E-stage flush
module hazard_tag_pipe
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rdD,
    input  logic              wrD,
    input  logic              ldD,
    output logic [REG_AW-1:0] rs1E,
    output logic [REG_AW-1:0] rs2E,
    output logic [REG_AW-1:0] rdE,
    output logic              wrE,
    output logic              ldE,
    output logic [REG_AW-1:0] rdM,
    output logic              wrM,
    output logic [REG_AW-1:0] rdW,
    output logic              wrW
);

    e_tag_t e_tag;

    // A flushed E slot becomes a bubble that neither writes nor loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_tag <= '0;
            rdM   <= '0;
            wrM   <= 1'b0;
            rdW   <= '0;
            wrW   <= 1'b0;
        end else begin
            if (flush)
                e_tag <= '0;
            else
                e_tag <= '{rs1: rs1D, rs2: rs2D, rd: rdD, wr: wrD, ld: ldD};
            rdM <= e_tag.rd;
            wrM <= e_tag.wr;
            rdW <= rdM;
            wrW <= wrM;
        end
    end

    assign rs1E = e_tag.rs1;
    assign rs2E = e_tag.rs2;
    assign rdE  = e_tag.rd;
    assign wrE  = e_tag.wr;
    assign ldE  = e_tag.ld;

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - load-use stall, control flush and forward select; perf counters under HAZARD_PERF_EN
module hazard_scheduler
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rdD,
    input  logic              reg_writeD,
    input  logic [1:0]        result_srcD,
    input  logic              pc_srcE,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic              wrD;
    logic              ldD;
    logic [REG_AW-1:0] rs1E;
    logic [REG_AW-1:0] rs2E;
    logic [REG_AW-1:0] rdE;
    logic              wrE;
    logic              ldE;
    logic [REG_AW-1:0] rdM;
    logic              wrM;
    logic [REG_AW-1:0] rdW;
    logic              wrW;
    logic              lw_hazard;
    logic              ctl_flush;

    assign wrD = reg_writeD && (rdD != '0);
    assign ldD = wrD && (result_srcD == RES_SRC_LOAD);

    // Gating with rst_n makes every output drop the moment reset asserts,
    // even though pc_srcE comes straight from the inputs.
    assign lw_hazard = rst_n && ldE && (rdE == rs1D || rdE == rs2D) && !pc_srcE;
    assign ctl_flush = rst_n && pc_srcE;

    assign stallF = lw_hazard;
    assign stallD = lw_hazard;
    assign flushD = ctl_flush;
    assign flushE = lw_hazard || ctl_flush;

    assign forwardAE = rst_n ? fwd_sel(rs1E, rdM, wrM, rdW, wrW) : FWD_RF;
    assign forwardBE = rst_n ? fwd_sel(rs2E, rdM, wrM, rdW, wrW) : FWD_RF;

    hazard_tag_pipe u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flushE),
        .rs1D  (rs1D),
        .rs2D  (rs2D),
        .rdD   (rdD),
        .wrD   (wrD),
        .ldD   (ldD),
        .rs1E  (rs1E),
        .rs2E  (rs2E),
        .rdE   (rdE),
        .wrE   (wrE),
        .ldE   (ldE),
        .rdM   (rdM),
        .wrM   (wrM),
        .rdW   (rdW),
        .wrW   (wrW)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (lw_hazard)
                stall_q <= stall_q + 32'd1;
            if (ctl_flush)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cnt = rst_n ? stall_q : '0;
    assign flush_cnt = rst_n ? flush_q : '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - self-checking bench: directed hazard scenarios plus random traffic vs an instruction-record model
module tb_hazard_scheduler;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1D, rs2D, rdD;
    logic       reg_writeD;
    logic [1:0] result_srcD;
    logic       pc_srcE;
    logic       stallF, stallD, flushD, flushE;
    logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1D        (rs1D),
        .rs2D        (rs2D),
        .rdD         (rdD),
        .reg_writeD  (reg_writeD),
        .result_srcD (result_srcD),
        .pc_srcE     (pc_srcE),
        .stallF      (stallF),
        .stallD      (stallD),
        .flushD      (flushD),
        .flushE      (flushE),
        .forwardAE   (forwardAE),
        .forwardBE   (forwardBE)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one record per instruction occupying E, M and W.
    typedef struct {
        logic [4:0] rs1, rs2, rd;
        bit         wr, ld;
    } instr_t;

    instr_t e_i, m_i, w_i, dec_i;
    bit     x_stall, x_flushd, x_flushe;
    logic [1:0] x_fa, x_fb;
    logic [31:0] n_stall, n_flush;

    function automatic logic [1:0] producer_sel(input logic [4:0] src);
        if (m_i.wr && m_i.rd == src) return 2'd2;
        if (w_i.wr && w_i.rd == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        e_i = '{default: 0};
        m_i = '{default: 0};
        w_i = '{default: 0};
        n_stall = 0;
        n_flush = 0;
    endtask

    task automatic predict_and_check();
        dec_i.rs1 = rs1D;
        dec_i.rs2 = rs2D;
        dec_i.rd  = rdD;
        dec_i.wr  = reg_writeD && rdD != 0;
        dec_i.ld  = dec_i.wr && result_srcD == 2'b01;
        if (!rst_n) begin
            x_stall = 0; x_flushd = 0; x_flushe = 0; x_fa = 0; x_fb = 0;
        end else begin
            x_stall  = e_i.ld && (e_i.rd == rs1D || e_i.rd == rs2D) && !pc_srcE;
            x_flushd = pc_srcE;
            x_flushe = x_stall || pc_srcE;
            x_fa     = producer_sel(e_i.rs1);
            x_fb     = producer_sel(e_i.rs2);
        end
        chk("stallF", stallF, x_stall);
        chk("stallD", stallD, x_stall);
        chk("flushD", flushD, x_flushd);
        chk("flushE", flushE, x_flushe);
        chk("forwardAE", forwardAE, x_fa);
        chk("forwardBE", forwardBE, x_fb);
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt, rst_n ? n_stall : 32'd0);
        chk("flush_cnt", flush_cnt, rst_n ? n_flush : 32'd0);
`endif
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic rw, input logic [1:0] rsrc, input logic pc);
        rs1D = a; rs2D = b; rdD = d;
        reg_writeD = rw; result_srcD = rsrc; pc_srcE = pc;
        #1;
        predict_and_check();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (x_stall) n_stall = n_stall + 1;
            if (x_flushd) n_flush = n_flush + 1;
            w_i = m_i;
            m_i = e_i;
            e_i = x_flushe ? '{default: 0} : dec_i;
        end else begin
            model_clear();
        end
        #1;
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        // Reset held with a taken branch and a load/consumer pair on the inputs
        drive(5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1);
        chk("rst_flushD", flushD, 1'b0);
        chk("rst_flushE", flushE, 1'b0);
        tick();
        drive(5'd5, 5'd7, 5'd6, 1'b1, 2'b00, 1'b1);
        tick();
        rst_n = 1'b1;
        drive(5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 1'b0);
        chk("post_rst_fa", forwardAE, 2'b00);
        chk("post_rst_fb", forwardBE, 2'b00);
        chk("post_rst_stall", stallF, 1'b0);
        tick();

        // add x5,x1,x2 ; add x6,x5,x5
        drive(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0); tick();
        drive(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("fwd_dist1_a", forwardAE, 2'b10);
        chk("fwd_dist1_b", forwardBE, 2'b10);
        tick();

        // add x5,x1,x2 ; add x9,x10,x11 ; add x6,x5,x8
        drive(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0); tick();
        drive(5'd10, 5'd11, 5'd9, 1'b1, 2'b00, 1'b0); tick();
        drive(5'd5, 5'd8, 5'd6, 1'b1, 2'b00, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("fwd_dist2_a", forwardAE, 2'b01);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0); tick();

        // lw x5,0(x1) ; sub x6,x5,x7 : one stall, then forward from W
        drive(5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0); tick();
        drive(5'd5, 5'd7, 5'd6, 1'b1, 2'b00, 1'b0);
        chk("lu_stallF", stallF, 1'b1);
        chk("lu_stallD", stallD, 1'b1);
        chk("lu_flushE", flushE, 1'b1);
        tick();
        drive(5'd5, 5'd7, 5'd6, 1'b1, 2'b00, 1'b0);
        chk("lu_once", stallF, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("lu_fwd_wb", forwardAE, 2'b01);
`ifdef HAZARD_PERF_EN
        chk("lu_stall_cnt", stall_cnt, 32'd1);
`endif
        tick();

        // Branch: flush for one cycle, squashed producer never forwards
        drive(5'd1, 5'd2, 5'd4, 1'b1, 2'b00, 1'b1);
        chk("br_flushD", flushD, 1'b1);
        chk("br_flushE", flushE, 1'b1);
        tick();
        drive(5'd4, 5'd4, 5'd8, 1'b1, 2'b00, 1'b0);
        chk("br_flush_once", flushD, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("br_no_fwd", forwardAE, 2'b00);
        tick();

        // Load-use match coinciding with a taken branch
        drive(5'd1, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0); tick();
        drive(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b1);
        chk("sim_stallF", stallF, 1'b0);
        chk("sim_stallD", stallD, 1'b0);
        chk("sim_flushD", flushD, 1'b1);
        chk("sim_flushE", flushE, 1'b1);
        tick();

        // addi x0,x0,1 ; add x3,x0,x0
        drive(5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd3, 1'b1, 2'b00, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("x0_fa", forwardAE, 2'b00);
        tick();

        // Reset asserted mid-stall drops outputs immediately
        drive(5'd2, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0); tick();
        drive(5'd7, 5'd3, 5'd9, 1'b1, 2'b00, 1'b1);
        drive(5'd7, 5'd3, 5'd9, 1'b1, 2'b00, 1'b0);
        chk("mid_stall", stallF, 1'b1);
        rst_n = 1'b0;
        #1;
        model_clear();
        predict_and_check();
        chk("mid_rst_stallF", stallF, 1'b0);
        chk("mid_rst_flushE", flushE, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(5'd7, 5'd3, 5'd9, 1'b1, 2'b00, 1'b0);
        chk("rel_stall", stallF, 1'b0);
        tick();

`ifdef HAZARD_PERF_EN
        force dut.flush_q = 32'hFFFF_FFFF;
        #1;
        release dut.flush_q;
        n_flush = 32'hFFFF_FFFF;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("flush_wrap", flush_cnt, 32'd0);
        tick();
`endif

        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 5) == 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
